// File: rtl/trap_sequencer.sv
// Supervisor trap sequencer: accepts exceptions, interrupts and SRET, then steps flush/save/redirect.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when stvec[1:0] == 2'b01.
module trap_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [63:0] exc_epc,
  input  logic        irq_pending,
  input  logic [4:0]  irq_cause,
  input  logic        sie,
  input  logic        sret_req,
  input  logic [63:0] stvec,
  output logic        exc_ack,
  output logic        sret_ack,
  output logic        stall,
  output logic        flush,
  output logic        csr_we,
  output logic [31:0] scause,
  output logic [63:0] sepc,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        in_trap
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_SAVE     = 3'd2,
    S_REDIRECT = 3'd3,
    S_RETURN   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] scause_q, scause_d;
  logic [63:0] sepc_q, sepc_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        in_trap_q, in_trap_d;
  logic        flush_q, flush_d;
  logic        csr_we_q, csr_we_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        stall_q, stall_d;
  logic        exc_ack_s, sret_ack_s;
  logic        irq_take_s;
  logic [63:0] trap_base_s, trap_target_s;

  assign irq_take_s  = irq_pending & sie & ~in_trap_q;
  assign trap_base_s = {stvec[63:2], 2'b00};

  // Trap target; interrupts may be vectored, exceptions always land on the base.
  always_comb begin
`ifdef TRAP_VECTORED_EN
    if ((stvec[1:0] == 2'b01) && scause_q[31]) begin
      trap_target_s = trap_base_s + {57'd0, scause_q[4:0], 2'b00};
    end else begin
      trap_target_s = trap_base_s;
    end
`else
    trap_target_s = trap_base_s;
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic unused_s;
  assign unused_s = ^stvec[1:0];
`endif

  // Next-state, CSR capture and strobe decode.
  always_comb begin
    state_d       = state_q;
    scause_d      = scause_q;
    sepc_d        = sepc_q;
    redirect_pc_d = redirect_pc_q;
    in_trap_d     = in_trap_q;
    exc_ack_s     = 1'b0;
    sret_ack_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          exc_ack_s = 1'b1;
          scause_d  = exc_cause;
          sepc_d    = {exc_epc[63:1], 1'b0};
          state_d   = S_FLUSH;
        end else if (irq_take_s) begin
          scause_d = {1'b1, 26'd0, irq_cause};
          sepc_d   = exc_epc;
          state_d  = S_FLUSH;
        end else if (sret_req) begin
          sret_ack_s    = 1'b1;
          redirect_pc_d = sepc_q;
          state_d       = S_RETURN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH:    state_d = S_SAVE;
      S_SAVE: begin
        in_trap_d     = 1'b1;
        redirect_pc_d = trap_target_s;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: state_d = S_IDLE;
      S_RETURN: begin
        in_trap_d = 1'b0;
        state_d   = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they line up with the state they belong to.
    flush_d          = (state_d == S_FLUSH) || (state_d == S_RETURN);
    csr_we_d         = (state_d == S_SAVE);
    redirect_valid_d = (state_d == S_REDIRECT) || (state_d == S_RETURN);
    stall_d          = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      scause_q         <= 32'd0;
      sepc_q           <= 64'd0;
      redirect_pc_q    <= 64'd0;
      in_trap_q        <= 1'b0;
      flush_q          <= 1'b0;
      csr_we_q         <= 1'b0;
      redirect_valid_q <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      scause_q         <= scause_d;
      sepc_q           <= sepc_d;
      redirect_pc_q    <= redirect_pc_d;
      in_trap_q        <= in_trap_d;
      flush_q          <= flush_d;
      csr_we_q         <= csr_we_d;
      redirect_valid_q <= redirect_valid_d;
      stall_q          <= stall_d;
    end
  end

  // Acks are same-cycle acceptance pulses, forced low while reset is held.
  assign exc_ack        = exc_ack_s & reset;
  assign sret_ack       = sret_ack_s & reset;
  assign stall          = stall_q;
  assign flush          = flush_q;
  assign csr_we         = csr_we_q;
  assign scause         = scause_q;
  assign sepc           = sepc_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_trap        = in_trap_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; expected values are hand-computed per cycle.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [63:0] exc_epc;
  logic        irq_pending;
  logic [4:0]  irq_cause;
  logic        sie;
  logic        sret_req;
  logic [63:0] stvec;
  logic        exc_ack, sret_ack, stall, flush, csr_we, redirect_valid, in_trap;
  logic [31:0] scause;
  logic [63:0] sepc, redirect_pc;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef TRAP_VECTORED_EN
  localparam logic [63:0] IRQ_TARGET = 64'h1014;
`else
  localparam logic [63:0] IRQ_TARGET = 64'h1000;
`endif

  trap_sequencer dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_epc(exc_epc), .irq_pending(irq_pending), .irq_cause(irq_cause), .sie(sie),
    .sret_req(sret_req), .stvec(stvec), .exc_ack(exc_ack), .sret_ack(sret_ack),
    .stall(stall), .flush(flush), .csr_we(csr_we), .scause(scause), .sepc(sepc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_trap(in_trap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; exc_valid = 1'b0; exc_cause = 32'd0; exc_epc = 64'd0;
    irq_pending = 1'b0; irq_cause = 5'd0; sie = 1'b0; sret_req = 1'b0; stvec = 64'd0;
    tick(); tick();
    check_val("rst_stall", {63'd0, stall}, 64'd0);
    check_val("rst_flush", {63'd0, flush}, 64'd0);
    check_val("rst_scause", {32'd0, scause}, 64'd0);
    check_val("rst_sepc", sepc, 64'd0);
    check_val("rst_rpc", redirect_pc, 64'd0);
    check_val("rst_in_trap", {63'd0, in_trap}, 64'd0);
    reset = 1'b1;
    tick();

    // Exception and interrupt together: exception wins.
    stvec = 64'h1000; exc_valid = 1'b1; exc_cause = 32'd2; exc_epc = 64'h20;
    irq_pending = 1'b1; sie = 1'b1; irq_cause = 5'd5;
    #1;
    check_val("exc_ack_N", {63'd0, exc_ack}, 64'd1);
    check_val("stall_N", {63'd0, stall}, 64'd0);
    tick(); exc_valid = 1'b0;
    check_val("flush_N1", {63'd0, flush}, 64'd1);
    check_val("stall_N1", {63'd0, stall}, 64'd1);
    check_val("csr_we_N1", {63'd0, csr_we}, 64'd0);
    tick();
    check_val("csr_we_N2", {63'd0, csr_we}, 64'd1);
    check_val("flush_N2", {63'd0, flush}, 64'd0);
    check_val("scause_N2", {32'd0, scause}, 64'h2);
    check_val("sepc_N2", sepc, 64'h20);
    check_val("in_trap_N2", {63'd0, in_trap}, 64'd0);
    tick();
    check_val("rv_N3", {63'd0, redirect_valid}, 64'd1);
    check_val("rpc_N3", redirect_pc, 64'h1000);
    check_val("in_trap_N3", {63'd0, in_trap}, 64'd1);
    tick();
    check_val("rv_N4", {63'd0, redirect_valid}, 64'd0);
    check_val("stall_N4", {63'd0, stall}, 64'd0);
    tick();
    check_val("irq_masked_in_trap", {63'd0, stall}, 64'd0);
    check_val("scause_hold", {32'd0, scause}, 64'h2);

    // SRET back to 0x20; interrupt then taken with vector-capable stvec.
    sret_req = 1'b1; stvec = 64'h1001; exc_epc = 64'h45;
    #1;
    check_val("sret_ack", {63'd0, sret_ack}, 64'd1);
    tick(); sret_req = 1'b0;
    check_val("ret_rv", {63'd0, redirect_valid}, 64'd1);
    check_val("ret_flush", {63'd0, flush}, 64'd1);
    check_val("ret_rpc", redirect_pc, 64'h20);
    check_val("ret_in_trap", {63'd0, in_trap}, 64'd1);
    tick();
    check_val("post_ret_in_trap", {63'd0, in_trap}, 64'd0);
    check_val("irq_no_ack", {63'd0, exc_ack}, 64'd0);
    tick(); irq_pending = 1'b0;
    check_val("irq_flush", {63'd0, flush}, 64'd1);
    check_val("irq_scause", {32'd0, scause}, 64'h80000005);
    check_val("irq_sepc", sepc, 64'h45);
    tick();
    check_val("irq_csr_we", {63'd0, csr_we}, 64'd1);
    tick();
    check_val("irq_rv", {63'd0, redirect_valid}, 64'd1);
    check_val("irq_rpc", redirect_pc, IRQ_TARGET);
    tick();

    // Nested exception with odd PC while in_trap.
    exc_valid = 1'b1; exc_cause = 32'hD; exc_epc = 64'h31;
    #1;
    check_val("nest_ack", {63'd0, exc_ack}, 64'd1);
    tick(); exc_valid = 1'b0;
    check_val("nest_scause", {32'd0, scause}, 64'hD);
    check_val("nest_sepc_even", sepc, 64'h30);
    tick(); tick();
    check_val("nest_rpc_base", redirect_pc, 64'h1000);
    check_val("nest_in_trap", {63'd0, in_trap}, 64'd1);
    tick();

    // Reset while in SAVE abandons the sequence.
    exc_valid = 1'b1; exc_cause = 32'd7; exc_epc = 64'h80;
    tick(); exc_valid = 1'b0;
    tick();
    check_val("save_csr_we", {63'd0, csr_we}, 64'd1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_csr_we", {63'd0, csr_we}, 64'd0);
    check_val("mid_rst_stall", {63'd0, stall}, 64'd0);
    check_val("mid_rst_scause", {32'd0, scause}, 64'd0);
    check_val("mid_rst_sepc", sepc, 64'd0);
    check_val("mid_rst_rpc", redirect_pc, 64'd0);
    check_val("mid_rst_in_trap", {63'd0, in_trap}, 64'd0);
    tick();
    check_val("rst_hold_rv", {63'd0, redirect_valid}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_rst_rv", {63'd0, redirect_valid}, 64'd0);
      check_val("post_rst_csr_we", {63'd0, csr_we}, 64'd0);
    end

    // SRET with in_trap clear; exception arriving in RETURN waits for IDLE.
    sret_req = 1'b1;
    #1;
    check_val("sret0_ack", {63'd0, sret_ack}, 64'd1);
    tick(); sret_req = 1'b0; exc_valid = 1'b1; exc_cause = 32'd3; exc_epc = 64'h100;
    check_val("sret0_rv", {63'd0, redirect_valid}, 64'd1);
    check_val("sret0_rpc", redirect_pc, 64'd0);
    check_val("busy_no_ack", {63'd0, exc_ack}, 64'd0);
    tick();
    check_val("idle_ack", {63'd0, exc_ack}, 64'd1);
    tick(); exc_valid = 1'b0;
    check_val("late_scause", {32'd0, scause}, 64'h3);
    check_val("late_sepc", sepc, 64'h100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 exc_valid  input  1  exception request from exception detection unit; held by source until exc_ack.
REQ-004 exc_cause  input  32  exception code (scause format, bit 31 = 0).
REQ-005 exc_epc  input  64  PC of faulting instruction.
REQ-006 irq_pending  input  1  supervisor interrupt request, level.
REQ-007 irq_cause  input  5  interrupt code.
REQ-008 sie  input  1  global supervisor interrupt enable.
REQ-009 sret_req  input  1  SRET instruction reached commit; held until sret_ack.
REQ-010 stvec  input  64  trap vector CSR value; [1:0] = mode, [63:2] = base.
REQ-011 exc_ack / sret_ack  output  1 each  single-cycle acceptance pulses.
REQ-012 stall  output  1  freeze pipeline front end.
REQ-013 flush  output  1  kill all in-flight instructions.
REQ-014 csr_we  output  1  write strobe for scause/sepc CSRs.
REQ-015 scause  output  32  registered trap cause.
REQ-016 sepc  output  64  registered trap PC.
REQ-017 redirect_valid  output  1  fetch PC override strobe.
REQ-018 redirect_pc  output  64  new fetch PC.
REQ-019 in_trap  output  1  handler active flag.

Function
REQ-020 FSM states SHALL be IDLE, FLUSH, SAVE, REDIRECT, RETURN; encoding free.
REQ-021 In IDLE, priority SHALL be exc_valid > (irq_pending & sie & ~in_trap) > sret_req; one request accepted per cycle.
REQ-022 Accepting exception: exc_ack=1 that cycle, latch scause=exc_cause, sepc={exc_epc[63:1],1'b0}, go FLUSH.
REQ-023 Accepting interrupt: latch scause={1'b1,26'b0,irq_cause}, sepc=exc_epc, go FLUSH; no ack.
REQ-024 FLUSH: flush=1 exactly one cycle, then SAVE.
REQ-025 SAVE: csr_we=1 exactly one cycle, in_trap set at end of cycle, then REDIRECT.
REQ-026 REDIRECT: redirect_valid=1 one cycle, redirect_pc={stvec[63:2],2'b00}, then IDLE.
REQ-027 Latency: request accepted cycle N -> flush N+1, csr_we N+2, redirect_valid N+3.
REQ-028 Accepting sret_req: sret_ack=1, go RETURN; RETURN drives redirect_valid=1, redirect_pc=sepc, flush=1, clears in_trap, then IDLE.
REQ-029 stall SHALL be 1 in every state except IDLE.
REQ-030 Requests arriving outside IDLE SHALL be ignored (not lost: sources hold until ack); sampled again in IDLE.
REQ-031 Exception while in_trap SHALL still be taken, overwriting scause/sepc; in_trap remains 1.
REQ-032 sret_req with in_trap=0 SHALL still be executed (returns to current sepc).
REQ-033 scause/sepc SHALL hold value between traps; change only on acceptance.

Reset
REQ-034 reset low SHALL immediately force IDLE, all strobes 0, stall 0, in_trap 0, scause 0, sepc 0, redirect_pc 0.
REQ-035 Reset mid-sequence SHALL abandon it with no csr_we or redirect_valid emitted afterwards.

Configuration
REQ-036 Macro TRAP_VECTORED_EN: when defined and stvec[1:0]=2'b01, interrupt redirect_pc SHALL be base + 4*irq_cause; exceptions always use base.
REQ-037 Without TRAP_VECTORED_EN, stvec[1:0] SHALL be ignored; all traps use base.

Verification
REQ-038 Exception: exc_valid=1, exc_cause=2, exc_epc=0x20, stvec=0x1000 -> exc_ack N, flush N+1, csr_we N+2 with scause=0x2 sepc=0x20, redirect_pc=0x1000 at N+3.
REQ-039 Odd PC: exc_epc=0x31 -> sepc=0x30.
REQ-040 Simultaneous exc_valid and irq_pending (sie=1) -> exception taken; interrupt taken after return with scause=0x80000005 (irq_cause=5).
REQ-041 Vectored (macro on): stvec=0x1001, irq_cause=5 -> redirect_pc=0x1014; macro off -> 0x1000.
REQ-042 SRET after trap: sret_req=1 -> sret_ack, redirect_pc=0x20, in_trap 1->0, interrupts re-enabled.
REQ-043 Reset asserted in SAVE state -> all outputs zero immediately, no redirect_valid pulse follows.
